push_button_conditioner: RTL and testbench

//   Front-end for the five board push buttons. Feeds the service blocks (time set, alarm set,

---
 rtl/push_button_conditioner_pkg.sv | 28 ++
 rtl/push_button_conditioner_btn_channel.sv | 148 ++++++++++++++
 rtl/push_button_conditioner.sv | 37 +++
 tb/tb_push_button_conditioner.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/push_button_conditioner_pkg.sv
// Shared definitions for the push button front-end: button indices,
// repeat FSM state encoding and small width helpers.
package push_button_conditioner_pkg;

  // Bit positions of the board buttons inside push_raw / btn_* vectors
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_M = 4;

  // Auto-repeat state per button
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Counter width able to hold max_val without wrapping
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/push_button_conditioner_btn_channel.sv
// One button lane: two-flop synchronizer, counting debouncer, registered
// press/release pulses and an optional auto-repeat FSM.
module btn_channel
  import push_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int REPEAT_DELAY  = 382,
  parameter int REPEAT_PERIOD = 76,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic push_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int DW = cnt_width(DEBOUNCE_CYC - 1);
  localparam int RW = cnt_width(max_int(REPEAT_DELAY - 1, REPEAT_PERIOD - 1));

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [DW-1:0] dcnt;
  logic          accept;
  logic          rise;
  logic          fall;

  rpt_state_t    state;
  rpt_state_t    state_next;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_next;
  logic          repeat_fire;

  logic          press_q;
  logic          release_q;

  // Bring the asynchronous raw input into the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= push_raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      dcnt   <= '0;
    end else if (s2 == stable) begin
      dcnt <= '0;
    end else if (dcnt == DEB_LAST) begin
      stable <= s2;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  assign accept = (s2 != stable) && (dcnt == DEB_LAST);
  assign rise   = accept && s2;
  assign fall   = accept && !s2;

  // Repeat FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      rcnt  <= rcnt_next;
    end
  end

  // Repeat FSM next state; a release always wins over a pending repeat
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_HELD;
          rcnt_next  = '0;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end else if (REPEAT_EN && (rcnt == DELAY_LAST)) begin
          state_next = ST_REPEAT;
          rcnt_next  = '0;
        end else if (rcnt != DELAY_LAST) begin
          rcnt_next = rcnt + RW'(1);
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          state_next = ST_IDLE;
          rcnt_next  = '0;
        end else if (rcnt == PERIOD_LAST) begin
          rcnt_next = '0;
        end else begin
          rcnt_next = rcnt + RW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        rcnt_next  = '0;
      end
    endcase
  end

  // Repeat FSM output: fire when the delay or period count expires
  always_comb begin
    repeat_fire = 1'b0;
    case (state)
      ST_HELD:   repeat_fire = REPEAT_EN && !fall && (rcnt == DELAY_LAST);
      ST_REPEAT: repeat_fire = !fall && (rcnt == PERIOD_LAST);
      default:   repeat_fire = 1'b0;
    endcase
  end

  // Register the one-cycle pulses so they line up with the level change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= rise || repeat_fire;
      release_q <= fall;
    end
  end

  assign btn_level   = stable;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/push_button_conditioner.sv
// Front-end for the board push buttons: one independent conditioning
// lane per button, auto-repeat enabled per lane by REPEAT_MASK.
module push_button_conditioner
  import push_button_conditioner_pkg::*;
#(
  parameter int               N_BTN         = 5,
  parameter int               DEBOUNCE_CYC  = 16,
  parameter int               REPEAT_DELAY  = 382,
  parameter int               REPEAT_PERIOD = 76,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 5'b00011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] push_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One lane per button, fully independent of the others
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_channel #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_EN     (REPEAT_MASK[i])
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .push_raw    (push_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_push_button_conditioner.sv
// Bench for push_button_conditioner: directed scenarios plus random button
// activity, checked each cycle against a sliding-window / elapsed-time model.
module tb_push_button_conditioner;

  localparam int          NB   = 5;
  localparam int          DEB  = 4;
  localparam int          DLY  = 10;
  localparam int          PER  = 3;
  localparam logic [4:0]  MASK = 5'b00011;

  logic          clk;
  logic          reset;
  logic [NB-1:0] push_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int checks;
  int errors;

  // Reference model state
  bit         hist [NB][$];
  bit         lvl [NB];
  int         rise_edge [NB];
  int         edge_cnt;
  logic [4:0] exp_level;
  logic [4:0] exp_press;
  logic [4:0] exp_release;

  int press_seen [NB];
  int release_seen [NB];

  push_button_conditioner #(
    .N_BTN         (NB),
    .DEBOUNCE_CYC  (DEB),
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER),
    .REPEAT_MASK   (MASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push_raw    (push_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model: the last DEB synchronized samples (raw samples two or more edges
  // old) all disagreeing with the level flips it; repeats are timed from the
  // edge of the accepted press.
  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      hist[b].delete();
      for (int j = 0; j <= DEB; j++) hist[b].push_back(1'b0);
      lvl[b]       = 1'b0;
      rise_edge[b] = 0;
    end
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
  endtask

  task automatic model_step(input logic [4:0] raw);
    edge_cnt++;
    for (int b = 0; b < NB; b++) begin
      bit flip;
      bit p;
      bit r;
      int n;
      flip = 1'b1;
      p    = 1'b0;
      r    = 1'b0;
      for (int j = 0; j < DEB; j++) begin
        if (hist[b][j] == lvl[b]) flip = 1'b0;
      end
      if (flip) begin
        lvl[b] = !lvl[b];
        if (lvl[b]) begin
          p            = 1'b1;
          rise_edge[b] = edge_cnt;
        end else begin
          r = 1'b1;
        end
      end else if (lvl[b] && MASK[b]) begin
        n = edge_cnt - rise_edge[b];
        if (n >= DLY && ((n - DLY) % PER) == 0) p = 1'b1;
      end
      hist[b].push_back(raw[b]);
      void'(hist[b].pop_front());
      exp_level[b]   = lvl[b];
      exp_press[b]   = p;
      exp_release[b] = r;
    end
  endtask

  task automatic clear_counts();
    for (int b = 0; b < NB; b++) begin
      press_seen[b]   = 0;
      release_seen[b] = 0;
    end
  endtask

  // One clock cycle: drive on the falling edge, model on the rising edge, check just after
  task automatic applyStimulus(input logic [4:0] value, input logic rst_val);
    @(negedge clk);
    push_raw = value;
    reset    = rst_val;
    @(posedge clk);
    if (reset) model_step(value);
    else model_reset();
    #1;
    checkOutput("level", 32'(btn_level), 32'(exp_level));
    checkOutput("press", 32'(btn_press), 32'(exp_press));
    checkOutput("release", 32'(btn_release), 32'(exp_release));
    for (int b = 0; b < NB; b++) begin
      press_seen[b]   += int'(btn_press[b]);
      release_seen[b] += int'(btn_release[b]);
    end
  endtask

  task automatic hold(input logic [4:0] value, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(value, 1'b1);
  endtask

  initial begin
    logic [4:0] cur;
    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    push_raw = '0;
    reset    = 1'b1;
    clear_counts();
    model_reset();

    // Reset asserted with all buttons held: outputs must be low right away
    #2;
    reset    = 1'b0;
    push_raw = 5'b11111;
    #1;
    checkOutput("rst_level", 32'(btn_level), 32'd0);
    checkOutput("rst_press", 32'(btn_press), 32'd0);
    checkOutput("rst_release", 32'(btn_release), 32'd0);
    repeat (3) applyStimulus(5'b11111, 1'b0);

    // Buttons held through reset release count as a fresh press
    clear_counts();
    hold(5'b11111, 8);
    for (int b = 0; b < NB; b++) checkOutput($sformatf("t1_press%0d", b), 32'(press_seen[b]), 32'd1);
    hold(5'b00000, 8);

    // Single clean press of up, shorter than the repeat delay
    clear_counts();
    hold(5'b00001, 8);
    hold(5'b00000, 10);
    checkOutput("t2_press", 32'(press_seen[0]), 32'd1);
    checkOutput("t2_release", 32'(release_seen[0]), 32'd1);

    // Bouncing down button, then a steady hold
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      hold(5'b00010, 2);
      hold(5'b00000, 2);
    end
    checkOutput("t3_bounce_press", 32'(press_seen[1]), 32'd0);
    hold(5'b00010, 10);
    checkOutput("t3_press", 32'(press_seen[1]), 32'd1);
    checkOutput("t3_release", 32'(release_seen[1]), 32'd0);
    hold(5'b00000, 8);

    // Long hold: up repeats (press + 7 repeats), middle does not
    clear_counts();
    hold(5'b00001, 30);
    hold(5'b00000, 10);
    checkOutput("t4_u_presses", 32'(press_seen[0]), 32'd8);
    clear_counts();
    hold(5'b10000, 30);
    hold(5'b00000, 10);
    checkOutput("t4_m_presses", 32'(press_seen[4]), 32'd1);

    // Left and right together
    clear_counts();
    hold(5'b01100, 8);
    hold(5'b00000, 8);
    checkOutput("t5_l_press", 32'(press_seen[2]), 32'd1);
    checkOutput("t5_r_press", 32'(press_seen[3]), 32'd1);

    // Reset between edges while up is repeating
    hold(5'b00001, 20);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_level", 32'(btn_level), 32'd0);
    checkOutput("t6_press", 32'(btn_press), 32'd0);
    checkOutput("t6_release", 32'(btn_release), 32'd0);
    model_reset();
    repeat (3) applyStimulus(5'b00001, 1'b0);
    clear_counts();
    hold(5'b00001, 5);
    checkOutput("t6_no_stale", 32'(press_seen[0]), 32'd0);
    hold(5'b00001, 3);
    checkOutput("t6_fresh", 32'(press_seen[0]), 32'd1);
    hold(5'b00000, 10);

    // Random button activity with occasional long holds
    cur = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 99) < 6) cur[b] = !cur[b];
      end
      applyStimulus(cur, 1'b1);
    end
    hold(5'b00000, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
